// File: rtl/reg_writeback_queue.sv
// rtl/reg_writeback_queue.sv - register-file write-back queue merging ALU and load results
//
// Purpose:
//   Buffers register-write requests from the ALU and memory-load paths in a
//   small FIFO and drains one entry per cycle onto the register-file write
//   port (WriteReg / WriteData / Reg_write_Control).
//
// Configuration:
//   WBQ_BYPASS_EN  when defined, adds LookupReg / LookupHit / LookupData and a
//                  combinational youngest-match search over the queued writes
//                  and the write currently presented to the register file.
//
// Ports:
//   Clock              in   1              rising-edge clock
//   Reset              in   1              synchronous, active-high
//   AluValid/AluReady  in/out 1            ALU request handshake
//   AluReg/AluData     in   ADDR_W/DATA_W  ALU destination and result
//   MemValid/MemReady  in/out 1            load request handshake
//   MemReg/MemData     in   ADDR_W/DATA_W  load destination and data
//   WbStall            in   1              1 = register-file port unavailable
//   WriteReg           out  ADDR_W         register-file write address
//   WriteData          out  DATA_W         register-file write data
//   Reg_write_Control  out  1              register-file write enable
//   LookupReg          in   ADDR_W         (WBQ_BYPASS_EN) register to search for
//   LookupHit          out  1              (WBQ_BYPASS_EN) a pending write exists
//   LookupData         out  DATA_W         (WBQ_BYPASS_EN) youngest pending value
//   Pending            out  $clog2(DEPTH)+1 FIFO occupancy

module reg_writeback_queue #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    AluValid,
    output logic                    AluReady,
    input  logic [ADDR_W-1:0]       AluReg,
    input  logic [DATA_W-1:0]       AluData,
    input  logic                    MemValid,
    output logic                    MemReady,
    input  logic [ADDR_W-1:0]       MemReg,
    input  logic [DATA_W-1:0]       MemData,
    input  logic                    WbStall,
    output logic [ADDR_W-1:0]       WriteReg,
    output logic [DATA_W-1:0]       WriteData,
    output logic                    Reg_write_Control,
`ifdef WBQ_BYPASS_EN
    input  logic [ADDR_W-1:0]       LookupReg,
    output logic                    LookupHit,
    output logic [DATA_W-1:0]       LookupData,
`endif
    output logic [$clog2(DEPTH):0]  Pending
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // DEPTH must be a power of two so the pointers can wrap by truncation.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gBadDepth
        $error("reg_writeback_queue: DEPTH must be a power of 2 and >= 2");
    end

    logic [ADDR_W-1:0] regMem  [DEPTH];
    logic [DATA_W-1:0] dataMem [DEPTH];

    logic [PTR_W-1:0]  rdPtr;
    logic [PTR_W-1:0]  wrPtr;
    logic [CNT_W-1:0]  count;

    logic              memPush;
    logic              aluPush;
    logic              doPop;
    logic [PTR_W-1:0]  aluSlot;
    logic [CNT_W-1:0]  pushCnt;

    // Readiness looks only at the registered occupancy, so there is no
    // combinational path from either valid to either ready. A pop in the
    // same cycle is deliberately not credited. AluReady asks for two free
    // slots so that a simultaneous Mem+Alu pair always fits.
    assign MemReady = (count < CNT_W'(DEPTH));
    assign AluReady = (count < CNT_W'(DEPTH - 1));

    // Writes to r0 complete the handshake but are dropped here.
    assign memPush = MemValid && MemReady && (MemReg != '0);
    assign aluPush = AluValid && AluReady && (AluReg != '0);
    assign doPop   = (count != '0) && !WbStall;

    // When both sources push, the load entry takes the older slot.
    assign aluSlot = memPush ? (wrPtr + PTR_W'(1)) : wrPtr;
    assign pushCnt = CNT_W'(memPush) + CNT_W'(aluPush);

    assign Pending = count;

    // Storage needs no reset: entries are only ever read below count.
    always_ff @(posedge Clock) begin
        if (memPush) begin
            regMem[wrPtr]  <= MemReg;
            dataMem[wrPtr] <= MemData;
        end
        if (aluPush) begin
            regMem[aluSlot]  <= AluReg;
            dataMem[aluSlot] <= AluData;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            rdPtr             <= '0;
            wrPtr             <= '0;
            count             <= '0;
            WriteReg          <= '0;
            WriteData         <= '0;
            Reg_write_Control <= 1'b0;
        end else begin
            // pushCnt of 2 wraps correctly even when PTR_W is 1.
            wrPtr             <= wrPtr + PTR_W'(pushCnt);
            count             <= count + pushCnt - CNT_W'(doPop);
            Reg_write_Control <= doPop;
            if (doPop) begin
                WriteReg  <= regMem[rdPtr];
                WriteData <= dataMem[rdPtr];
                rdPtr     <= rdPtr + PTR_W'(1);
            end
        end
    end

`ifdef WBQ_BYPASS_EN
    // Scan from oldest to youngest so a later match overrides an earlier
    // one. The entry on the register-file port is older than every queued
    // entry, so it is considered first.
    always_comb begin
        LookupHit  = 1'b0;
        LookupData = '0;
        if (LookupReg != '0) begin
            if (Reg_write_Control && (WriteReg == LookupReg)) begin
                LookupHit  = 1'b1;
                LookupData = WriteData;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if ((CNT_W'(i) < count) && (regMem[rdPtr + PTR_W'(i)] == LookupReg)) begin
                    LookupHit  = 1'b1;
                    LookupData = dataMem[rdPtr + PTR_W'(i)];
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_reg_writeback_queue.sv
// tb/tb_reg_writeback_queue.sv - scoreboard bench for reg_writeback_queue
module tb_reg_writeback_queue;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 3;

    typedef struct packed {
        logic [ADDR_W-1:0] r;
        logic [DATA_W-1:0] d;
    } wr_t;

    logic              Clock;
    logic              Reset;
    logic              AluValid;
    logic              AluReady;
    logic [ADDR_W-1:0] AluReg;
    logic [DATA_W-1:0] AluData;
    logic              MemValid;
    logic              MemReady;
    logic [ADDR_W-1:0] MemReg;
    logic [DATA_W-1:0] MemData;
    logic              WbStall;
    logic [ADDR_W-1:0] WriteReg;
    logic [DATA_W-1:0] WriteData;
    logic              Reg_write_Control;
    logic [CNT_W-1:0]  Pending;
`ifdef WBQ_BYPASS_EN
    logic [ADDR_W-1:0] LookupReg;
    logic              LookupHit;
    logic [DATA_W-1:0] LookupData;
`endif

    reg_writeback_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .Clock(Clock),
        .Reset(Reset),
        .AluValid(AluValid),
        .AluReady(AluReady),
        .AluReg(AluReg),
        .AluData(AluData),
        .MemValid(MemValid),
        .MemReady(MemReady),
        .MemReg(MemReg),
        .MemData(MemData),
        .WbStall(WbStall),
        .WriteReg(WriteReg),
        .WriteData(WriteData),
        .Reg_write_Control(Reg_write_Control),
`ifdef WBQ_BYPASS_EN
        .LookupReg(LookupReg),
        .LookupHit(LookupHit),
        .LookupData(LookupData),
`endif
        .Pending(Pending)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference model: queued writes, writes already issued to the register
    // file (awaiting the monitor), and what the write port should show.
    wr_t               modelQ[$];
    wr_t               sbQ[$];
    logic              expRwc  = 1'b0;
    logic [ADDR_W-1:0] expReg  = '0;
    logic [DATA_W-1:0] expData = '0;
    int                lookupSel = -1;

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic stall,
                        input logic mv, input logic [ADDR_W-1:0] mr, input logic [DATA_W-1:0] md,
                        input logic av, input logic [ADDR_W-1:0] ar, input logic [DATA_W-1:0] ad,
                        output logic memAcc, output logic aluAcc);
        int  freeSlots;
        wr_t w;
        @(negedge Clock);
        freeSlots = DEPTH - modelQ.size();
        chk("pending",   Pending,           modelQ.size());
        chk("mem_ready", MemReady,          freeSlots >= 1);
        chk("alu_ready", AluReady,          freeSlots >= 2);
        chk("reg_write", Reg_write_Control, expRwc);
        chk("write_reg", WriteReg,          expReg);
        chk("write_data", WriteData,        expData);

        Reset    = rst;
        WbStall  = stall;
        MemValid = mv;
        MemReg   = mr;
        MemData  = md;
        AluValid = av;
        AluReg   = ar;
        AluData  = ad;
`ifdef WBQ_BYPASS_EN
        begin
            logic              eHit;
            logic [DATA_W-1:0] eData;
            LookupReg = (lookupSel >= 0) ? ADDR_W'(lookupSel) : ADDR_W'($urandom_range(0, 7));
            #1;
            eHit  = 1'b0;
            eData = '0;
            if (LookupReg != '0) begin
                for (int i = modelQ.size() - 1; i >= 0 && !eHit; i--) begin
                    if (modelQ[i].r == LookupReg) begin
                        eHit  = 1'b1;
                        eData = modelQ[i].d;
                    end
                end
                if (!eHit && expRwc && expReg == LookupReg) begin
                    eHit  = 1'b1;
                    eData = expData;
                end
            end
            chk("lookup_hit",  LookupHit,  eHit);
            chk("lookup_data", LookupData, eData);
        end
`endif

        memAcc = mv && (freeSlots >= 1) && !rst;
        aluAcc = av && (freeSlots >= 2) && !rst;
        if (rst) begin
            modelQ.delete();
            expRwc  = 1'b0;
            expReg  = '0;
            expData = '0;
        end else begin
            if (modelQ.size() > 0 && !stall) begin
                w = modelQ.pop_front();
                sbQ.push_back(w);
                expRwc  = 1'b1;
                expReg  = w.r;
                expData = w.d;
            end else begin
                expRwc = 1'b0;
            end
            if (memAcc && mr != '0) modelQ.push_back({mr, md});
            if (aluAcc && ar != '0) modelQ.push_back({ar, ad});
        end
    endtask

    task automatic idle(input int n);
        logic a, b;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, a, b);
    endtask

    // Monitor: every write-enable pulse must match the next issued write.
    always @(negedge Clock) begin : mon
        wr_t w;
        if (Reg_write_Control === 1'b1) begin
            if (sbQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL sb_spurious: got write r%0d=%0h expected no write at %0t", WriteReg, WriteData, $time);
            end else begin
                w = sbQ.pop_front();
                chk("sb_reg",  WriteReg,  w.r);
                chk("sb_data", WriteData, w.d);
            end
        end
    end

    initial begin : stim
        logic              a, b;
        logic              mv, av, stall, rst;
        logic [ADDR_W-1:0] mr, ar;
        logic [DATA_W-1:0] md, ad;

        Reset = 1'b1; WbStall = 1'b0;
        MemValid = 1'b0; MemReg = '0; MemData = '0;
        AluValid = 1'b0; AluReg = '0; AluData = '0;
`ifdef WBQ_BYPASS_EN
        LookupReg = '0;
`endif

        // Reset for two cycles.
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, a, b);
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, a, b);

        // Single ALU write.
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 5'd1, 32'h9ABCDEF0, a, b);
        idle(3);

        // Simultaneous Mem and Alu: r2 first, then r5.
        step(1'b0, 1'b0, 1'b1, 5'd2, 32'h2, 1'b1, 5'd5, 32'h5, a, b);
        idle(3);

        // Write to r0 is swallowed.
        step(1'b0, 1'b0, 1'b1, 5'd0, 32'h12345678, 1'b0, '0, '0, a, b);
        idle(2);

        // Fill under stall, hold, then release.
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b1, 1'b1, ADDR_W'(10 + i), 32'hA000_0000 + i, 1'b0, '0, '0, a, b);
        step(1'b0, 1'b1, 1'b1, 5'd20, 32'hDEAD, 1'b1, 5'd21, 32'hBEEF, a, b);
        idle(6);

        // Same register twice, youngest wins; then reset mid-drain.
        lookupSel = 3;
        step(1'b0, 1'b1, 1'b1, 5'd3, 32'h11, 1'b0, '0, '0, a, b);
        step(1'b0, 1'b1, 1'b1, 5'd3, 32'h22, 1'b0, '0, '0, a, b);
        step(1'b0, 1'b1, 1'b1, 5'd7, 32'h77, 1'b0, '0, '0, a, b);
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, a, b);
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, a, b);
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, a, b);
        lookupSel = -1;
        idle(2);

        // Randomized traffic; sources hold a request until it is accepted.
        mv = 1'b0; av = 1'b0; mr = '0; ar = '0; md = '0; ad = '0;
        for (int n = 0; n < 2000; n++) begin
            if (!mv) begin
                mv = ($urandom_range(0, 2) != 0);
                mr = ADDR_W'($urandom_range(0, 7));
                md = $urandom;
            end
            if (!av) begin
                av = ($urandom_range(0, 2) != 0);
                ar = ADDR_W'($urandom_range(0, 7));
                ad = $urandom;
            end
            stall = ($urandom_range(0, 3) == 0);
            rst   = ($urandom_range(0, 199) == 0);
            step(rst, stall, mv, mr, md, av, ar, ad, a, b);
            if (a || rst) mv = 1'b0;
            if (b || rst) av = 1'b0;
        end

        idle(DEPTH + 4);
        chk("sb_drained", sbQ.size(), 0);
        chk("model_drained", modelQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
